// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE256 core between the sampler buffer (A) and the seed/matrix expander (B).
// A grant lasts for the whole absorb/squeeze session, and the core is held in reset between owners.
module shake_arbiter #(
    parameter int RST_CYCLES = 2,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          rel_a,
    input  logic          rel_b,
    output logic          gnt_a,
    output logic          gnt_b,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic          a_in_ready,
    input  logic          b_in_ready,
    input  logic          a_is_last,
    input  logic          b_is_last,
    input  logic [1:0]    a_byte_num,
    input  logic [1:0]    b_byte_num,
    input  logic          a_rst,
    input  logic          b_rst,
    output logic          a_out_ready,
    output logic          b_out_ready,
    output logic          core_rst,
    output logic [DW-1:0] core_in,
    output logic          core_in_ready,
    output logic          core_is_last,
    output logic [1:0]    core_byte_num,
    input  logic          core_out_ready,
    output logic          busy
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CTR_LAST = CW'(RST_CYCLES - 1);
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {IDLE, SETUP, OWN} state_t;

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [CW-1:0] rst_ctr;
    logic          owner_rel;

    assign owner_rel = (owner == OWNER_B) ? rel_b : rel_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWNER_A;
            last_owner <= OWNER_B;
            rst_ctr    <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        // With both requesting, the side that did not own last wins.
                        owner   <= (req_a && req_b) ? ~last_owner : req_b;
                        rst_ctr <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (rst_ctr == CTR_LAST) begin
                        gnt_a <= (owner == OWNER_A);
                        gnt_b <= (owner == OWNER_B);
                        state <= OWN;
                    end else begin
                        rst_ctr <= rst_ctr + 1'b1;
                    end
                end
                OWN: begin
                    if (owner_rel) begin
                        gnt_a      <= 1'b0;
                        gnt_b      <= 1'b0;
                        last_owner <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Core-side mux: outside OWN the core sits in reset and the non-owner never reaches it.
    always_comb begin
        core_rst      = 1'b1;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = 2'b00;
        if (state == OWN) begin
            if (owner == OWNER_B) begin
                core_rst      = b_rst;
                core_in       = b_in;
                core_in_ready = b_in_ready;
                core_is_last  = b_is_last;
                core_byte_num = b_byte_num;
            end else begin
                core_rst      = a_rst;
                core_in       = a_in;
                core_in_ready = a_in_ready;
                core_is_last  = a_is_last;
                core_byte_num = a_byte_num;
            end
        end
    end

    assign a_out_ready = gnt_a & core_out_ready;
    assign b_out_ready = gnt_b & core_out_ready;
    assign busy        = (state != IDLE);

    gnt_onehot: assert property (@(posedge clk) disable iff (!rst) !(gnt_a && gnt_b));

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: a fixed cycle table, hand-written corner sequences and a randomized
// phase compared against a cycle-timeline model of the arbitration rules.
module tb_shake_arbiter;

    localparam int DW = 32;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_a = 0, req_b = 0, rel_a = 0, rel_b = 0;
    logic          gnt_a, gnt_b;
    logic [DW-1:0] a_in = '0, b_in = '0;
    logic          a_in_ready = 0, b_in_ready = 0, a_is_last = 0, b_is_last = 0;
    logic [1:0]    a_byte_num = 0, b_byte_num = 0;
    logic          a_rst = 0, b_rst = 0;
    logic          a_out_ready, b_out_ready;
    logic          core_rst;
    logic [DW-1:0] core_in;
    logic          core_in_ready, core_is_last;
    logic [1:0]    core_byte_num;
    logic          core_out_ready = 0;
    logic          busy;

    always #5 clk = ~clk;

    shake_arbiter #(.RST_CYCLES(RC), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .rel_a(rel_a), .rel_b(rel_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .a_in(a_in), .b_in(b_in),
        .a_in_ready(a_in_ready), .b_in_ready(b_in_ready),
        .a_is_last(a_is_last), .b_is_last(b_is_last),
        .a_byte_num(a_byte_num), .b_byte_num(b_byte_num),
        .a_rst(a_rst), .b_rst(b_rst),
        .a_out_ready(a_out_ready), .b_out_ready(b_out_ready),
        .core_rst(core_rst), .core_in(core_in), .core_in_ready(core_in_ready),
        .core_is_last(core_is_last), .core_byte_num(core_byte_num),
        .core_out_ready(core_out_ready), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit ra, rb, la, lb, av, bv, ar, br, cor;
        bit ga, gb, bsy, crst, cv, aor, bor;
    } vec_t;

    vec_t tbl[24];

    // Timeline model state for the random phase
    bit idle_m, own_m, last_m, granted;
    int gcyc;

    initial begin
        //          ra rb la lb av bv ar br cor | ga gb bsy crst cv aor bor
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 1, 0, 1, 1,   1, 0, 1, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1,   1, 0, 1, 1, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 1, 0, 0, 1,   0, 1, 1, 0, 1, 0, 1};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[15] = '{1, 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[19] = '{1, 1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0};
        tbl[20] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0};
        tbl[21] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[22] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[23] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0};

        // Reset state
        #12;
        chk("rst_gnt", 64'({gnt_a, gnt_b}), 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_core_in_ready", 64'(core_in_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Table: single A session, isolation, non-owner release, alternation
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            req_a = tbl[k].ra; req_b = tbl[k].rb; rel_a = tbl[k].la; rel_b = tbl[k].lb;
            a_in_ready = tbl[k].av; b_in_ready = tbl[k].bv; a_rst = tbl[k].ar; b_rst = tbl[k].br;
            core_out_ready = tbl[k].cor;
            a_in = 32'hA000_0000 + k; b_in = 32'hB000_0000 + k;
            a_is_last = k[0]; b_is_last = ~k[0];
            a_byte_num = k[1:0]; b_byte_num = ~k[1:0];
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", k), 64'({gnt_a, gnt_b}), 64'({tbl[k].ga, tbl[k].gb}));
            chk($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].bsy));
            chk($sformatf("tbl%0d_core_rst", k), 64'(core_rst), 64'(tbl[k].crst));
            chk($sformatf("tbl%0d_core_in_ready", k), 64'(core_in_ready), 64'(tbl[k].cv));
            chk($sformatf("tbl%0d_out_ready", k), 64'({a_out_ready, b_out_ready}), 64'({tbl[k].aor, tbl[k].bor}));
            chk($sformatf("tbl%0d_core_in", k), 64'(core_in),
                64'(tbl[k].ga ? 32'hA000_0000 + k : tbl[k].gb ? 32'hB000_0000 + k : 32'd0));
            chk($sformatf("tbl%0d_core_last", k), 64'({core_is_last, core_byte_num}),
                64'(tbl[k].ga ? {k[0], k[1:0]} : tbl[k].gb ? {~k[0], ~k[1:0]} : 3'd0));
        end

        // Asynchronous reset while A owns: everything drops within the same cycle
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("midrst_gnt", 64'({gnt_a, gnt_b}), 64'd0);
        chk("midrst_core_rst", 64'(core_rst), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_first_winner", 64'({gnt_a, gnt_b}), 64'b10);

        // A streams 9 words plus a last word, releasing in the same cycle as the last word
        req_a = 0; req_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_in = $urandom; a_in_ready = 1'b1; a_is_last = (i == 9);
            a_byte_num = (i == 9) ? 2'd2 : 2'($urandom_range(0, 3));
            b_in = $urandom; b_in_ready = 1'b1; b_rst = 1'($urandom_range(0, 1));
            core_out_ready = 1'(i % 2); rel_a = (i == 9); a_rst = 1'b0;
            @(negedge clk);
            chk($sformatf("word%0d_data", i), 64'(core_in), 64'(a_in));
            chk($sformatf("word%0d_ctl", i), 64'({core_in_ready, core_is_last, core_byte_num, core_rst}),
                64'({1'b1, (i == 9), a_byte_num, 1'b0}));
            chk($sformatf("word%0d_out_ready", i), 64'({a_out_ready, b_out_ready}), 64'({1'(i % 2), 1'b0}));
        end
        @(posedge clk); #1 rel_a = 1'b0;
        @(negedge clk);
        chk("after_rel_gnt", 64'({gnt_a, gnt_b}), 64'd0);
        chk("after_rel_core", 64'({core_rst, core_in_ready}), 64'b10);

        // Randomized phase against the timeline model
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        idle_m = 1; last_m = 1; own_m = 0; gcyc = 0;
        for (int n = 0; n < 3000; n++) begin
            req_a = ($urandom_range(0, 3) == 0); req_b = ($urandom_range(0, 3) == 0);
            rel_a = ($urandom_range(0, 5) == 0); rel_b = ($urandom_range(0, 5) == 0);
            a_in = $urandom; b_in = $urandom;
            a_in_ready = 1'($urandom_range(0, 1)); b_in_ready = 1'($urandom_range(0, 1));
            a_is_last = 1'($urandom_range(0, 1)); b_is_last = 1'($urandom_range(0, 1));
            a_byte_num = 2'($urandom_range(0, 3)); b_byte_num = 2'($urandom_range(0, 3));
            a_rst = ($urandom_range(0, 7) == 0); b_rst = ($urandom_range(0, 7) == 0);
            core_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            granted = !idle_m && (n >= gcyc);
            chk("rnd_gnt", 64'({gnt_a, gnt_b}), 64'({granted && !own_m, granted && own_m}));
            chk("rnd_busy", 64'(busy), 64'(!idle_m));
            chk("rnd_core_rst", 64'(core_rst), 64'(granted ? (own_m ? b_rst : a_rst) : 1'b1));
            chk("rnd_core_in", 64'(core_in), 64'(granted ? (own_m ? b_in : a_in) : 32'd0));
            chk("rnd_core_ctl", 64'({core_in_ready, core_is_last, core_byte_num}),
                64'(granted ? (own_m ? {b_in_ready, b_is_last, b_byte_num} : {a_in_ready, a_is_last, a_byte_num}) : 4'd0));
            chk("rnd_out_ready", 64'({a_out_ready, b_out_ready}),
                64'({granted && !own_m && core_out_ready, granted && own_m && core_out_ready}));
            if (idle_m) begin
                if (req_a || req_b) begin
                    own_m  = (req_a && req_b) ? !last_m : req_b;
                    idle_m = 0;
                    gcyc   = n + 1 + RC;
                end
            end else if (granted && (own_m ? rel_b : rel_a)) begin
                idle_m = 1;
                last_m = own_m;
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
